// File: rtl/wb_regfile.sv
// wb_regfile -- writeback stage and architectural register file.
//
// Selects the writeback value from the MEM/WB bundle, commits it into a
// 2**ADDR_W entry register file (r0 hardwired to zero), serves two
// combinational decode read ports and counts committed writes.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   WB_W[1:0]        {RegWrite, MemtoReg}
//   ReadData_W       load data
//   ALUOut_W         ALU result
//   WriteReg_W       destination index
//   RA1_D / RA2_D    read indices (rs / rt)
//   RD1_D / RD2_D    read data
//   Result_W         selected writeback value (to forwarding unit)
//   WriteCount       committed register writes, wraps modulo 2**CNT_W
//
// Build option: define WB_REGFILE_BYPASS_EN to forward Result_W onto a read
// port that addresses the register being committed in the same cycle.
// Without it, reads return the stored (pre-write) value during that cycle.

module wb_rf_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                                   rst,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]     regs,
  input  logic [ADDR_W-1:0]                      ra,
  input  logic                                   byp_hit,
  input  logic [DATA_W-1:0]                      byp_data,
  output logic [DATA_W-1:0]                      rd
);
  // r0 reads zero even if a bypass would match; reset forces zero too.
  always_comb begin
    rd = regs[ra];
    if (rst || ra == '0) rd = '0;
    else if (byp_hit)    rd = byp_data;
  end
endmodule

module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        WB_W,
  input  logic [DATA_W-1:0] ReadData_W,
  input  logic [DATA_W-1:0] ALUOut_W,
  input  logic [ADDR_W-1:0] WriteReg_W,
  input  logic [ADDR_W-1:0] RA1_D,
  input  logic [ADDR_W-1:0] RA2_D,
  output logic [DATA_W-1:0] RD1_D,
  output logic [DATA_W-1:0] RD2_D,
  output logic [DATA_W-1:0] Result_W,
  output logic [CNT_W-1:0]  WriteCount
);
  localparam int DEPTH   = 2**ADDR_W;
  localparam int NUM_RDP = 2;

  logic                             reg_write;
  logic                             mem_to_reg;
  logic                             rel_hold;
  logic                             commit;
  logic [DEPTH-1:0][DATA_W-1:0]     regs;
  logic [NUM_RDP-1:0][ADDR_W-1:0]   ra;
  logic [NUM_RDP-1:0][DATA_W-1:0]   rd;
  logic [NUM_RDP-1:0]               byp_hit;

  assign reg_write = WB_W[1];
  assign mem_to_reg = WB_W[0];
  assign Result_W  = mem_to_reg ? ReadData_W : ALUOut_W;

  // rel_hold stays set through the first edge after reset drops, so a write
  // presented on the release edge is ignored and commits start one edge later.
  always_ff @(posedge clk or posedge rst)
    if (rst) rel_hold <= 1'b1;
    else     rel_hold <= 1'b0;

  assign commit = reg_write && (WriteReg_W != '0) && !rst && !rel_hold;

  // regs[0] is never a commit target, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst)
    if (rst)         regs <= '0;
    else if (commit) regs[WriteReg_W] <= Result_W;

  always_ff @(posedge clk or posedge rst)
    if (rst)         WriteCount <= '0;
    else if (commit) WriteCount <= WriteCount + CNT_W'(1);

  assign ra = {RA2_D, RA1_D};

  for (genvar p = 0; p < NUM_RDP; p++) begin : g_rdp
`ifdef WB_REGFILE_BYPASS_EN
    assign byp_hit[p] = commit && (ra[p] == WriteReg_W);
`else
    assign byp_hit[p] = 1'b0;
`endif
    wb_rf_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdp (
      .rst      (rst),
      .regs     (regs),
      .ra       (ra[p]),
      .byp_hit  (byp_hit[p]),
      .byp_data (Result_W),
      .rd       (rd[p])
    );
  end

  assign RD1_D = rd[0];
  assign RD2_D = rd[1];
endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst, rst4;
  logic [1:0]  WB_W;
  logic [31:0] rdata, alu;
  logic [4:0]  wreg, ra1, ra2;
  logic [31:0] rd1, rd2, res, cnt;
  logic [31:0] rd1b, rd2b, resb;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  wb_regfile u_dut (
    .clk(clk), .rst(rst), .WB_W(WB_W), .ReadData_W(rdata), .ALUOut_W(alu),
    .WriteReg_W(wreg), .RA1_D(ra1), .RA2_D(ra2), .RD1_D(rd1), .RD2_D(rd2),
    .Result_W(res), .WriteCount(cnt)
  );

  wb_regfile #(.CNT_W(4)) u_w4 (
    .clk(clk), .rst(rst4), .WB_W(WB_W), .ReadData_W(rdata), .ALUOut_W(alu),
    .WriteReg_W(wreg), .RA1_D(ra1), .RA2_D(ra2), .RD1_D(rd1b), .RD2_D(rd2b),
    .Result_W(resb), .WriteCount(cnt4)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [32];
  int unsigned mcnt;
  int unsigned m4cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] res_m();
    return WB_W[0] ? rdata : alu;
  endfunction

  function automatic bit commit_m();
    return WB_W[1] && (wreg != 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
    if (commit_m() && a == wreg) return res_m();
`endif
    return mdl[a];
  endfunction

  task automatic drive(input logic [1:0] wb, input logic [31:0] rdv, input logic [31:0] alv,
                       input logic [4:0] wr, input logic [4:0] a1, input logic [4:0] a2);
    WB_W = wb; rdata = rdv; alu = alv; wreg = wr; ra1 = a1; ra2 = a2;
  endtask

  // One clock edge with the reference model updated from the presented bundle.
  task automatic step();
    @(posedge clk);
    if (commit_m()) begin
      mdl[wreg] = res_m();
      mcnt++;
    end
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    mcnt = 0;
  endtask

  initial begin
    rst = 1'b1; rst4 = 1'b1;
    drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    clear_model();
    m4cnt = 0;
    #12;
    @(negedge clk) rst = 1'b0;
    step();  // release edge
    chk("reset_cnt", cnt, 32'd0);
    drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd7, 5'd31);
    #1;
    chk("reset_rd1", rd1, 32'd0);
    chk("reset_rd2", rd2, 32'd0);

    // ALU path
    drive(2'b10, 32'hFFFF_FFFF, 32'h0000_0123, 5'd8, 5'd8, 5'd0);
    #1;
    chk("alu_result", res, 32'h123);
    step();
    chk("alu_rd1", rd1, 32'h123);
    chk("alu_cnt", cnt, 32'd1);

    // Load path
    drive(2'b11, 32'hCAFE_F00D, 32'h0, 5'd31, 5'd0, 5'd31);
    #1;
    chk("ld_result", res, 32'hCAFE_F00D);
    step();
    chk("ld_rd2", rd2, 32'hCAFE_F00D);
    chk("ld_cnt", cnt, 32'd2);

    // r0 write dropped, disabled write ignored
    drive(2'b10, 32'h0, 32'h44, 5'd4, 5'd0, 5'd4);
    step();
    drive(2'b10, 32'h0, 32'h55, 5'd0, 5'd0, 5'd4);
    step();
    drive(2'b00, 32'h0, 32'h77, 5'd4, 5'd0, 5'd4);
    #1;
    chk("r0_result_nowe", res, 32'h77);
    step();
    chk("r0_rd1", rd1, 32'd0);
    chk("r4_unchanged", rd2, 32'h44);
    chk("r0_cnt", cnt, 32'd3);

    // Same-cycle read/write of r9
    drive(2'b10, 32'h0, 32'h1, 5'd9, 5'd0, 5'd0);
    step();
    drive(2'b10, 32'h0, 32'h2, 5'd9, 5'd9, 5'd9);
    #1;
`ifdef WB_REGFILE_BYPASS_EN
    chk("same_pre_rd1", rd1, 32'h2);
    chk("same_pre_rd2", rd2, 32'h2);
`else
    chk("same_pre_rd1", rd1, 32'h1);
    chk("same_pre_rd2", rd2, 32'h1);
`endif
    step();
    chk("same_post_rd1", rd1, 32'h2);

    // Mid-cycle asynchronous reset
    drive(2'b10, 32'h0, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd0);
    step();
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd9);
    #1;
    chk("pre_rst_rd1", rd1, 32'hDEAD_BEEF);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rd1", rd1, 32'd0);
    chk("async_rst_rd2", rd2, 32'd0);
    chk("async_rst_cnt", cnt, 32'd0);
    clear_model();

    // No commit while reset held, none on the release edge
    drive(2'b10, 32'h0, 32'h0000_0ABC, 5'd3, 5'd3, 5'd0);
    #1;
    chk("rst_result", res, 32'hABC);
    @(posedge clk); #1;
    chk("rst_hold_rd1", rd1, 32'd0);
    chk("rst_hold_cnt", cnt, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_edge_rd1", rd1, 32'd0);
    chk("rel_edge_cnt", cnt, 32'd0);
    step();
    chk("post_rel_rd1", rd1, 32'hABC);
    chk("post_rel_cnt", cnt, 32'd1);
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [4:0] w;
      w = 5'($urandom_range(0, 31));
      drive(2'($urandom), $urandom, $urandom, w,
            ($urandom_range(0, 3) == 0) ? w : 5'($urandom),
            ($urandom_range(0, 3) == 0) ? w : 5'($urandom));
      #1;
      chk("rnd_result", res, res_m());
      chk("rnd_rd1", rd1, exp_rd(ra1));
      chk("rnd_rd2", rd2, exp_rd(ra2));
      step();
      chk("rnd_cnt", cnt, mcnt);
    end

    // 4-bit counter wrap on the second instance
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    @(negedge clk) rst4 = 1'b0;
    step();
    chk("w4_start", {28'd0, cnt4}, 32'd0);
    for (int n = 0; n < 17; n++) begin
      drive(2'b10, $urandom, $urandom, 5'($urandom_range(1, 31)), 5'd0, 5'd0);
      step();
      m4cnt = (m4cnt + 1) % 16;
    end
    chk("w4_wrap", {28'd0, cnt4}, 32'(m4cnt));
    chk("main_cnt_end", cnt, mcnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
